// File: rtl/os_generator.sv
// Gen1 ordered-set generator: streams TS1/TS2/IDLE (and SKP when OS_GEN_SKP_EN is defined) onto the PIPE TX bus.
// Start is accepted only while Busy is low, so every set is followed by at least one idle gap cycle.
module os_generator #(
    parameter int         LANESNUMBER = 16,
    parameter int         PIPEWIDTH   = 8,
    parameter logic [7:0] NFTS        = 8'hFF
) (
    input  logic                                  Pclk,
    input  logic                                  Reset,
    input  logic                                  OSGeneratorStart,
    input  logic [2:0]                            OSType,
    input  logic [1:0]                            LaneNumber,
    input  logic [7:0]                            LinkNumber,
    input  logic [2:0]                            Rate,
    input  logic                                  Loopback,
    output logic                                  OSGeneratorBusy,
    output logic                                  OSGeneratorFinish,
    output logic [PIPEWIDTH*LANESNUMBER-1:0]      TxData,
    output logic [(PIPEWIDTH/8)*LANESNUMBER-1:0]  TxDataK,
    output logic                                  TxDataValid
);
    localparam int SPB = PIPEWIDTH / 8;
    localparam int DW  = PIPEWIDTH * LANESNUMBER;
    localparam int KW  = SPB * LANESNUMBER;

    localparam logic [2:0] TYPE_TS1  = 3'b000;
    localparam logic [2:0] TYPE_TS2  = 3'b001;
    localparam logic [2:0] TYPE_IDLE = 3'b100;
`ifdef OS_GEN_SKP_EN
    localparam logic [2:0] TYPE_SKP  = 3'b010;
`endif
    localparam logic [3:0] TS_LAST    = 4'(16 / SPB - 1);
    localparam logic [3:0] SHORT_LAST = 4'(4 / SPB - 1);

    typedef enum logic {ST_IDLE, ST_SEND} osState_t;

    osState_t    stateReg, stateNext;
    logic [3:0]  beatCntReg, beatCntNext;
    logic [2:0]  typeReg;
    logic [7:0]  linkReg;
    logic [1:0]  laneNumReg;
    logic [2:0]  rateReg;
    logic        loopbackReg;

    logic        accept, emit, knownType, lastNow;
    logic [2:0]  srcType, srcRate;
    logic [7:0]  srcLink;
    logic [1:0]  srcLaneNum;
    logic        srcLoopback;
    logic [3:0]  beatIdx, lastBeat;
    logic [DW-1:0] beatData;
    logic [KW-1:0] beatK;

    // Returns {K, byte} for symbol s of a set on lane laneIdx.
    function automatic logic [8:0] symbolOf(input logic [2:0] t, input logic [7:0] link,
                                            input logic [1:0] laneNum, input logic [2:0] rate,
                                            input logic lb, input logic [3:0] s,
                                            input logic [7:0] laneIdx);
        logic [2:0] r;
        logic [7:0] rateId;
        symbolOf = 9'h000;
        r        = (rate == 3'd0) ? 3'd1 : rate;
        rateId   = ((8'h01 << ({1'b0, r} + 4'd1)) - 8'h01) & 8'h3E;
        if (t == TYPE_TS1 || t == TYPE_TS2) begin
            case (s)
                4'd0:    symbolOf = {1'b1, 8'hBC};
                4'd1:    symbolOf = (link == 8'h00) ? {1'b1, 8'hF7} : {1'b0, link};
                4'd2:    symbolOf = (laneNum == 2'b00) ? {1'b1, 8'hF7} : {1'b0, laneIdx};
                4'd3:    symbolOf = {1'b0, NFTS};
                4'd4:    symbolOf = {1'b0, rateId};
                4'd5:    symbolOf = {1'b0, 5'b0, lb, 2'b0};
                default: symbolOf = {1'b0, (t == TYPE_TS1) ? 8'h4A : 8'h45};
            endcase
        end
`ifdef OS_GEN_SKP_EN
        else if (t == TYPE_SKP) begin
            symbolOf = (s == 4'd0) ? {1'b1, 8'hBC} : {1'b1, 8'h1C};
        end
`endif
    endfunction

    // On the accepting edge the live inputs drive beat 0; afterwards the latched copy is used.
    always_comb begin
        accept      = (stateReg == ST_IDLE) && OSGeneratorStart && !OSGeneratorBusy;
        emit        = accept || (stateReg == ST_SEND);
        srcType     = accept ? OSType     : typeReg;
        srcLink     = accept ? LinkNumber : linkReg;
        srcLaneNum  = accept ? LaneNumber : laneNumReg;
        srcRate     = accept ? Rate       : rateReg;
        srcLoopback = accept ? Loopback   : loopbackReg;
        beatIdx     = accept ? 4'd0       : beatCntReg;
    end

    always_comb begin
        knownType = 1'b0;
        lastBeat  = 4'd0;
        case (srcType)
            TYPE_TS1, TYPE_TS2: begin knownType = 1'b1; lastBeat = TS_LAST;    end
            TYPE_IDLE:          begin knownType = 1'b1; lastBeat = SHORT_LAST; end
`ifdef OS_GEN_SKP_EN
            TYPE_SKP:           begin knownType = 1'b1; lastBeat = SHORT_LAST; end
`endif
            default:            ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < LANESNUMBER; gi++) begin : gLane
            logic [PIPEWIDTH-1:0] laneData;
            logic [SPB-1:0]       laneK;
            always_comb begin
                laneData = '0;
                laneK    = '0;
                for (int k = 0; k < SPB; k++) begin
                    {laneK[k], laneData[k*8 +: 8]} = symbolOf(srcType, srcLink, srcLaneNum, srcRate,
                                                              srcLoopback, 4'(int'(beatIdx) * SPB + k),
                                                              8'(gi));
                end
            end
            assign beatData[gi*PIPEWIDTH +: PIPEWIDTH] = laneData;
            assign beatK[gi*SPB +: SPB]                = laneK;
        end
    endgenerate

    always_comb begin
        stateNext   = stateReg;
        beatCntNext = beatCntReg;
        lastNow     = emit && (beatIdx == lastBeat);
        if (emit) begin
            if (lastNow) begin
                stateNext   = ST_IDLE;
                beatCntNext = 4'd0;
            end else begin
                stateNext   = ST_SEND;
                beatCntNext = beatIdx + 4'd1;
            end
        end
    end

    always_ff @(posedge Pclk or negedge Reset) begin
        if (!Reset) begin
            stateReg          <= ST_IDLE;
            beatCntReg        <= 4'd0;
            typeReg           <= 3'd0;
            linkReg           <= 8'd0;
            laneNumReg        <= 2'd0;
            rateReg           <= 3'd0;
            loopbackReg       <= 1'b0;
            OSGeneratorBusy   <= 1'b0;
            OSGeneratorFinish <= 1'b0;
            TxDataValid       <= 1'b0;
            TxData            <= '0;
            TxDataK           <= '0;
        end else begin
            stateReg          <= stateNext;
            beatCntReg        <= beatCntNext;
            if (accept) begin
                typeReg     <= OSType;
                linkReg     <= LinkNumber;
                laneNumReg  <= LaneNumber;
                rateReg     <= Rate;
                loopbackReg <= Loopback;
            end
            OSGeneratorBusy   <= emit;
            OSGeneratorFinish <= lastNow;
            TxDataValid       <= emit && knownType;
            TxData            <= (emit && knownType) ? beatData : '0;
            TxDataK           <= (emit && knownType) ? beatK    : '0;
        end
    end
endmodule
